// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Encodings shared by the multicycle MIPS controller, its ALU and their benches:
//   - opcode / funct field values
//   - alu_con operation select values
//   - alu_src_b and pc_source mux select values
//   - controller state enumeration
// Optional feature macro: MULTICYCLE_ADDI_EN adds the I_EXEC / I_WB states.
// ----------------------------------------------------------------------------
package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // R-type funct (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    // ALU operation select
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1111;

    // alu_src_b mux
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // pc_source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9
`ifdef MULTICYCLE_ADDI_EN
        ,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11
`endif
    } state_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the instruction register / ALU flag and the datapath controls.
//   master : controller side (drives controls, reads opcode/funct/zero)
//   slave  : datapath side
// There is no valid/ready handshake on this bundle: opcode/funct are expected
// to be held by the IR from the cycle after FETCH, and zero is a same-cycle
// combinational flag that the controller only looks at in BRANCH.
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_en;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [3:0]       alu_con;
    logic             illegal_op;
    logic             instr_done;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, funct, zero,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_con, illegal_op, instr_done, instr_cnt
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_con, illegal_op, instr_done, instr_cnt
    );
endinterface

// File: rtl/alu_funct_dec.sv
// ----------------------------------------------------------------------------
// alu_funct_dec
// Maps an R-type funct field to the ALU operation select.
//   funct   in  6  IR[5:0]
//   alu_con out 4  ALU operation (ADD when funct is not decoded)
//   valid   out 1  funct is one of the supported R-type operations
// ----------------------------------------------------------------------------
module alu_funct_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_con,
    output logic       valid
);
    always_comb begin
        alu_con = ALU_ADD;
        valid   = 1'b1;
        case (funct)
            FN_ADD:  alu_con = ALU_ADD;
            FN_SUB:  alu_con = ALU_SUB;
            FN_AND:  alu_con = ALU_AND;
            FN_OR:   alu_con = ALU_OR;
            FN_SLT:  alu_con = ALU_SLT;
            FN_SLL:  alu_con = ALU_SLL;
            default: valid   = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Moore control FSM for the multicycle MIPS datapath.
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   bus        master modport of multicycle_ctrl_if (opcode/funct/zero in,
//              datapath controls, illegal_op, instr_done, instr_cnt out)
//   state_dbg  out  current FSM state
// Optional feature macro: MULTICYCLE_ADDI_EN (ADDI via I_EXEC / I_WB; when
// undefined, opcode 001000 is treated as illegal).
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus,
    output state_t              state_dbg
);
    state_t           state, next_state;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       dec_con;
    logic             dec_valid;

    // Raw (pre-reset-gating) control values
    logic       pc_write, branch, illegal, done;
    logic       mem_read_c, mem_write_c, ir_write_c, reg_write_c;

    alu_funct_dec u_dec (
        .funct   (bus.funct),
        .alu_con (dec_con),
        .valid   (dec_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state     = state;
        pc_write       = 1'b0;
        branch         = 1'b0;
        illegal        = 1'b0;
        done           = 1'b0;
        mem_read_c     = 1'b0;
        mem_write_c    = 1'b0;
        ir_write_c     = 1'b0;
        reg_write_c    = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.pc_source  = PCSRC_ALU;
        bus.alu_con    = ALU_ADD;
        case (state)
            FETCH: begin
                mem_read_c    = 1'b1;
                ir_write_c    = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                pc_write      = 1'b1;
                next_state    = DECODE;
            end
            DECODE: begin
                // Branch target computed speculatively into ALUOut
                bus.alu_src_b = SRCB_IMM_SH2;
                case (bus.opcode)
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_R:         next_state = R_EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      next_state = I_EXEC;
`endif
                    default: begin
                        illegal    = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                next_state    = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read_c = 1'b1;
                bus.i_or_d = 1'b1;
                next_state = MEM_WB;
            end
            MEM_WB: begin
                reg_write_c    = 1'b1;
                bus.mem_to_reg = 1'b1;
                done           = 1'b1;
                next_state     = FETCH;
            end
            MEM_WR: begin
                mem_write_c = 1'b1;
                bus.i_or_d  = 1'b1;
                done        = 1'b1;
                next_state  = FETCH;
            end
            R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_con   = dec_con;
                if (dec_valid) begin
                    next_state = R_WB;
                end else begin
                    illegal    = 1'b1;
                    next_state = FETCH;
                end
            end
            R_WB: begin
                // ALU op held so ALUOut-based forwarding sees a stable op
                reg_write_c = 1'b1;
                bus.reg_dst = 1'b1;
                bus.alu_con = dec_con;
                done        = 1'b1;
                next_state  = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_con   = ALU_SUB;
                bus.pc_source = PCSRC_ALUOUT;
                branch        = 1'b1;
                done          = 1'b1;
                next_state    = FETCH;
            end
            JUMP: begin
                bus.pc_source = PCSRC_JUMP;
                pc_write      = 1'b1;
                done          = 1'b1;
                next_state    = FETCH;
            end
`ifdef MULTICYCLE_ADDI_EN
            I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                next_state    = I_WB;
            end
            I_WB: begin
                reg_write_c = 1'b1;
                done        = 1'b1;
                next_state  = FETCH;
            end
`endif
            default: next_state = FETCH;
        endcase
    end

    // Side-effecting strobes are masked during reset so nothing is written
    // while the datapath is held; the mux selects keep their FETCH values.
    assign bus.pc_en      = ~rst & (pc_write | (branch & bus.zero));
    assign bus.mem_read   = ~rst & mem_read_c;
    assign bus.mem_write  = ~rst & mem_write_c;
    assign bus.ir_write   = ~rst & ir_write_c;
    assign bus.reg_write  = ~rst & reg_write_c;
    assign bus.illegal_op = ~rst & illegal;
    assign bus.instr_done = ~rst & done;

    // Retired-instruction counter; wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt_q <= '0;
        else if (done) cnt_q <= cnt_q + 1'b1;
    end

    assign bus.instr_cnt = cnt_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl with CNT_W = 4.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import mips_pkg::*;

    localparam int CNT_W = 4;

    logic   clk;
    logic   rst;
    state_t state_dbg;
    int     checks;
    int     errors;
    logic [CNT_W-1:0] exp_cnt;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then sample 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = OP_J;
        bus.funct  = 6'd0;
        bus.zero   = 1'b0;
        #12;
        checks++;
        if (state_dbg !== FETCH) begin errors++; $display("FAIL rst_state got %0d exp %0d", state_dbg, FETCH); end
        checks++;
        if ({bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write, bus.illegal_op, bus.instr_done} !== 7'b0) begin
            errors++; $display("FAIL rst_enables got %b exp 0000000",
                {bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write, bus.illegal_op, bus.instr_done});
        end
        checks++;
        if (bus.alu_src_b !== SRCB_FOUR || bus.alu_con !== ALU_ADD) begin
            errors++; $display("FAIL rst_fetch_mux got srcb=%b alu=%b exp srcb=01 alu=0010", bus.alu_src_b, bus.alu_con);
        end
        checks++;
        if (bus.instr_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus.instr_cnt); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.mem_read, bus.ir_write, bus.pc_en} !== 3'b111) begin
            errors++; $display("FAIL rst_release_fetch got %b exp 111", {bus.mem_read, bus.ir_write, bus.pc_en});
        end
        exp_cnt = '0;
    endtask

    task automatic test_r_sub();
        bus.opcode = OP_R;
        bus.funct  = FN_SUB;
        checks++;
        if (state_dbg !== FETCH) begin errors++; $display("FAIL r_c1 got %0d exp %0d", state_dbg, FETCH); end
        tick();
        checks++;
        if (state_dbg !== DECODE || bus.alu_src_b !== SRCB_IMM_SH2) begin
            errors++; $display("FAIL r_c2 got st=%0d srcb=%b exp st=%0d srcb=11", state_dbg, bus.alu_src_b, DECODE);
        end
        tick();
        checks++;
        if (state_dbg !== R_EXEC || bus.alu_con !== ALU_SUB || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== SRCB_B) begin
            errors++; $display("FAIL r_c3 got st=%0d alu=%b a=%b b=%b exp st=%0d alu=0110 a=1 b=00",
                state_dbg, bus.alu_con, bus.alu_src_a, bus.alu_src_b, R_EXEC);
        end
        tick();
        checks++;
        if (state_dbg !== R_WB || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b1 || bus.instr_done !== 1'b1
            || bus.mem_to_reg !== 1'b0 || bus.alu_con !== ALU_SUB) begin
            errors++; $display("FAIL r_c4 got st=%0d rw=%b rd=%b done=%b m2r=%b alu=%b exp st=%0d rw=1 rd=1 done=1 m2r=0 alu=0110",
                state_dbg, bus.reg_write, bus.reg_dst, bus.instr_done, bus.mem_to_reg, bus.alu_con, R_WB);
        end
        checks++;
        if (bus.instr_cnt !== exp_cnt) begin errors++; $display("FAIL r_cnt_before got %0d exp %0d", bus.instr_cnt, exp_cnt); end
        tick();
        exp_cnt++;
        checks++;
        if (bus.instr_cnt !== exp_cnt || state_dbg !== FETCH) begin
            errors++; $display("FAIL r_cnt_after got cnt=%0d st=%0d exp cnt=%0d st=%0d", bus.instr_cnt, state_dbg, exp_cnt, FETCH);
        end
    endtask

    task automatic test_lw_sw();
        int done_cyc;
        int wr_cycles;
        // LW
        bus.opcode = OP_LW;
        done_cyc = 0;
        for (int c = 1; c <= 8; c++) begin
            if (state_dbg == MEM_RD) begin
                checks++;
                if (bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b1) begin
                    errors++; $display("FAIL lw_memrd got rd=%b iod=%b exp rd=1 iod=1", bus.mem_read, bus.i_or_d);
                end
            end
            if (state_dbg == MEM_WB) begin
                checks++;
                if (bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b1 || bus.reg_dst !== 1'b0) begin
                    errors++; $display("FAIL lw_memwb got rw=%b m2r=%b rd=%b exp rw=1 m2r=1 rd=0", bus.reg_write, bus.mem_to_reg, bus.reg_dst);
                end
            end
            if (bus.instr_done === 1'b1) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        checks++;
        if (done_cyc !== 5) begin errors++; $display("FAIL lw_latency got %0d exp 5", done_cyc); end
        tick();
        exp_cnt++;
        // SW
        bus.opcode = OP_SW;
        done_cyc = 0;
        wr_cycles = 0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.mem_write === 1'b1) begin
                wr_cycles++;
                checks++;
                if (state_dbg !== MEM_WR || bus.i_or_d !== 1'b1) begin
                    errors++; $display("FAIL sw_memwr got st=%0d iod=%b exp st=%0d iod=1", state_dbg, bus.i_or_d, MEM_WR);
                end
            end
            if (bus.instr_done === 1'b1) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        checks++;
        if (done_cyc !== 4 || wr_cycles !== 1) begin
            errors++; $display("FAIL sw_latency got cyc=%0d wr=%0d exp cyc=4 wr=1", done_cyc, wr_cycles);
        end
        tick();
        exp_cnt++;
        checks++;
        if (bus.instr_cnt !== exp_cnt) begin errors++; $display("FAIL lw_sw_cnt got %0d exp %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            bus.opcode = OP_BEQ;
            bus.zero   = 1'b0;
            tick();
            // zero raised during DECODE must not move the PC
            bus.zero = 1'b1;
            #1;
            checks++;
            if (state_dbg !== DECODE || bus.pc_en !== 1'b0) begin
                errors++; $display("FAIL beq_decode_zero got st=%0d pc_en=%b exp st=%0d pc_en=0", state_dbg, bus.pc_en, DECODE);
            end
            tick();
            bus.zero = z[0];
            #1;
            checks++;
            if (state_dbg !== BRANCH || bus.pc_en !== z[0] || bus.pc_source !== PCSRC_ALUOUT
                || bus.alu_con !== ALU_SUB || bus.instr_done !== 1'b1) begin
                errors++; $display("FAIL beq_z%0d got st=%0d pc_en=%b pcsrc=%b alu=%b done=%b exp st=%0d pc_en=%0d pcsrc=01 alu=0110 done=1",
                    z, state_dbg, bus.pc_en, bus.pc_source, bus.alu_con, bus.instr_done, BRANCH, z);
            end
            tick();
            exp_cnt++;
            bus.zero = 1'b0;
        end
        checks++;
        if (bus.instr_cnt !== exp_cnt) begin errors++; $display("FAIL beq_cnt got %0d exp %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_illegal();
        // Undecoded opcode
        bus.opcode = 6'b111111;
        tick();
        checks++;
        if (state_dbg !== DECODE || bus.illegal_op !== 1'b1 || bus.instr_done !== 1'b0) begin
            errors++; $display("FAIL ill_op got st=%0d ill=%b done=%b exp st=%0d ill=1 done=0", state_dbg, bus.illegal_op, bus.instr_done, DECODE);
        end
        tick();
        checks++;
        if (state_dbg !== FETCH || bus.illegal_op !== 1'b0) begin
            errors++; $display("FAIL ill_op_ret got st=%0d ill=%b exp st=%0d ill=0", state_dbg, bus.illegal_op, FETCH);
        end
        // Undecoded funct
        bus.opcode = OP_R;
        bus.funct  = 6'b000011;
        tick();
        checks++;
        if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL ill_fn_decode got ill=%b exp 0", bus.illegal_op); end
        tick();
        checks++;
        if (state_dbg !== R_EXEC || bus.illegal_op !== 1'b1 || bus.reg_write !== 1'b0) begin
            errors++; $display("FAIL ill_fn got st=%0d ill=%b rw=%b exp st=%0d ill=1 rw=0", state_dbg, bus.illegal_op, bus.reg_write, R_EXEC);
        end
        tick();
        checks++;
        if (state_dbg !== FETCH || bus.instr_cnt !== exp_cnt) begin
            errors++; $display("FAIL ill_fn_ret got st=%0d cnt=%0d exp st=%0d cnt=%0d", state_dbg, bus.instr_cnt, FETCH, exp_cnt);
        end
    endtask

    task automatic test_addi();
        bus.opcode = OP_ADDI;
        tick();
`ifdef MULTICYCLE_ADDI_EN
        checks++;
        if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL addi_decode got ill=%b exp 0", bus.illegal_op); end
        tick();
        checks++;
        if (state_dbg !== I_EXEC || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== SRCB_IMM || bus.alu_con !== ALU_ADD) begin
            errors++; $display("FAIL addi_exec got st=%0d a=%b b=%b alu=%b exp st=%0d a=1 b=10 alu=0010",
                state_dbg, bus.alu_src_a, bus.alu_src_b, bus.alu_con, I_EXEC);
        end
        tick();
        checks++;
        if (state_dbg !== I_WB || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0 || bus.mem_to_reg !== 1'b0 || bus.instr_done !== 1'b1) begin
            errors++; $display("FAIL addi_wb got st=%0d rw=%b rd=%b m2r=%b done=%b exp st=%0d rw=1 rd=0 m2r=0 done=1",
                state_dbg, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done, I_WB);
        end
        exp_cnt++;
`else
        checks++;
        if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL addi_illegal got ill=%b exp 1", bus.illegal_op); end
`endif
        tick();
        checks++;
        if (state_dbg !== FETCH || bus.instr_cnt !== exp_cnt) begin
            errors++; $display("FAIL addi_ret got st=%0d cnt=%0d exp st=%0d cnt=%0d", state_dbg, bus.instr_cnt, FETCH, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_lw();
        bus.opcode = OP_LW;
        tick();
        tick();
        tick();
        checks++;
        if (state_dbg !== MEM_RD) begin errors++; $display("FAIL rlw_reach got %0d exp %0d", state_dbg, MEM_RD); end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write, bus.instr_done} !== 6'b0
            || state_dbg !== FETCH || bus.instr_cnt !== 4'd0) begin
            errors++; $display("FAIL rlw_abort got en=%b st=%0d cnt=%0d exp en=000000 st=%0d cnt=0",
                {bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write, bus.instr_done},
                state_dbg, bus.instr_cnt, FETCH);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (state_dbg !== FETCH || {bus.mem_read, bus.ir_write, bus.pc_en} !== 3'b111 || bus.instr_cnt !== 4'd0) begin
            errors++; $display("FAIL rlw_release got st=%0d en=%b cnt=%0d exp st=%0d en=111 cnt=0",
                state_dbg, {bus.mem_read, bus.ir_write, bus.pc_en}, bus.instr_cnt, FETCH);
        end
        exp_cnt = '0;
    endtask

    task automatic test_wrap();
        bus.opcode = OP_J;
        for (int i = 0; i < 16; i++) begin
            tick();
            tick();
            checks++;
            if (state_dbg !== JUMP || bus.pc_source !== PCSRC_JUMP || bus.pc_en !== 1'b1 || bus.instr_done !== 1'b1) begin
                errors++; $display("FAIL j_%0d got st=%0d pcsrc=%b pc_en=%b done=%b exp st=%0d pcsrc=10 pc_en=1 done=1",
                    i, state_dbg, bus.pc_source, bus.pc_en, bus.instr_done, JUMP);
            end
            tick();
            exp_cnt++;
            checks++;
            if (state_dbg !== FETCH || bus.instr_cnt !== exp_cnt) begin
                errors++; $display("FAIL j_cnt_%0d got st=%0d cnt=%0d exp st=%0d cnt=%0d", i, state_dbg, bus.instr_cnt, FETCH, exp_cnt);
            end
        end
        checks++;
        if (bus.instr_cnt !== 4'd0) begin errors++; $display("FAIL wrap got %0d exp 0", bus.instr_cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = '0;
        test_reset();
        test_r_sub();
        test_lw_sw();
        test_beq();
        test_illegal();
        test_addi();
        test_reset_mid_lw();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run can never hang
    initial begin
        #50000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
